score_sequencer: RTL and testbench



---
 rtl/score_sequencer_pkg.sv | 39 +++
 rtl/score_sequencer_if.sv | 49 ++++
 rtl/score_sequencer_beat_timer.sv | 43 ++++
 rtl/score_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_score_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// score_sequencer_pkg
//
// Shared definitions for the buzzer score sequencer. The package holds the
// layout of a score ROM entry, the end-of-score and rest encodings, the
// sequencer state type and two helpers that split an entry into its fields.
//
// Score entry layout (16 bits):
//    [15:12] dur   note length in beat ticks, 0 = end-of-score marker
//    [11:0]  note  {high, med, low} note code, 0 = rest
// ---------------------------------------------------------------------------
package score_sequencer_pkg;

   localparam int ROM_W   = 16;
   localparam int DUR_MSB = 15;
   localparam int DUR_LSB = 12;
   localparam int DUR_W   = DUR_MSB - DUR_LSB + 1;
   localparam int NOTE_W  = 12;

   localparam logic [DUR_W-1:0]  END_DUR   = 4'd0;
   localparam logic [NOTE_W-1:0] REST_NOTE = 12'h000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } seq_state_t;

   // Duration field of a score entry
   function automatic logic [DUR_W-1:0] entry_dur(input logic [ROM_W-1:0] entry);
      return entry[DUR_MSB:DUR_LSB];
   endfunction

   // Note field of a score entry
   function automatic logic [NOTE_W-1:0] entry_note(input logic [ROM_W-1:0] entry);
      return entry[NOTE_W-1:0];
   endfunction

endpackage

// File: rtl/score_sequencer_if.sv
// ---------------------------------------------------------------------------
// score_sequencer_if
//
// Bundles the playback controls, the score ROM bus and the note outputs of
// the score sequencer.
//
// Signals:
//    start        one-cycle pulse, begin playback from address 0
//    stop         one-cycle pulse, abort playback
//    pause        level, freeze timing and mute while high
//    rom_addr     score ROM address (driven by the sequencer, registered)
//    rom_data     combinational ROM word {dur, note}
//    note_code    current note {high, med, low} for the frequency lookup
//    note_on      tone should sound
//    note_strobe  one-cycle pulse when note_code takes a new entry
//    playing      sequencer is not idle
//    done         one-cycle pulse at end of score (no loop) or empty score
//
// Modports:
//    master  controller side: drives controls and ROM data
//    slave   sequencer side: drives ROM address and note outputs
// ---------------------------------------------------------------------------
interface score_sequencer_if #(
   parameter int ADDR_W = 8
);
   import score_sequencer_pkg::*;

   logic              start;
   logic              stop;
   logic              pause;
   logic [ADDR_W-1:0] rom_addr;
   logic [ROM_W-1:0]  rom_data;
   logic [NOTE_W-1:0] note_code;
   logic              note_on;
   logic              note_strobe;
   logic              playing;
   logic              done;

   modport master (
      output start, stop, pause, rom_data,
      input  rom_addr, note_code, note_on, note_strobe, playing, done
   );

   modport slave (
      input  start, stop, pause, rom_data,
      output rom_addr, note_code, note_on, note_strobe, playing, done
   );

endinterface

// File: rtl/score_sequencer_beat_timer.sv
// ---------------------------------------------------------------------------
// beat_timer
//
// Divides the system clock into beat ticks. tick_cnt runs 0..TICK_DIV-1
// while en is high and wraps; wrap pulses on the cycle the counter sits at
// its last value with en high. clr returns the counter to 0 and wins over en.
//
// Ports:
//    clk       system clock
//    rst_n     asynchronous active-low reset
//    en        advance the counter this cycle
//    clr       synchronous clear to 0
//    wrap      counter is at TICK_DIV-1 and advancing (end of a beat)
//    tick_cnt  current position within the beat
// ---------------------------------------------------------------------------
module beat_timer #(
   parameter int TICK_DIV = 12500000,
   parameter int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   output logic              wrap,
   output logic [TICK_W-1:0] tick_cnt
);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   assign wrap = en && (tick_cnt == TICK_LAST);

   // Beat counter: clear has priority so a fresh note always starts at 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (clr) begin
         tick_cnt <= '0;
      end else if (en) begin
         tick_cnt <= wrap ? '0 : tick_cnt + TICK_W'(1);
      end
   end

endmodule

// File: rtl/score_sequencer.sv
// ---------------------------------------------------------------------------
// score_sequencer
//
// Upstream stage of the buzzer tone generator. Walks the score ROM one entry
// at a time, holds each note for dur beat ticks, and presents the note code
// to the frequency-lookup stage. Supports start/stop/pause, a short silent
// gap at the end of every note so repeated notes are distinguishable, an
// end-of-score marker (dur = 0) and optional looping.
//
// Parameters:
//    ADDR_W    score ROM address width
//    TICK_DIV  sys_clk cycles per beat tick (2..2^24)
//    GAP_CYC   silent cycles at the end of every note, must be < TICK_DIV
//    LOOP      1 = restart at address 0 after the marker, 0 = stop with done
//
// Ports:
//    sys_clk   system clock
//    rst_n     asynchronous active-low reset
//    bus       score_sequencer_if slave: controls, ROM bus, note outputs
// ---------------------------------------------------------------------------
module score_sequencer
   import score_sequencer_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int TICK_DIV = 12500000,
   parameter int GAP_CYC  = 1000000,
   parameter int LOOP     = 1
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   score_sequencer_if.slave  bus
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   // tick_cnt values below this still leave more than GAP_CYC cycles in the
   // last beat of a note
   localparam logic [31:0] SOUND_LIMIT = 32'(TICK_DIV - GAP_CYC);

   seq_state_t        state;
   seq_state_t        state_nxt;

   logic [ADDR_W-1:0] rom_addr;
   logic [NOTE_W-1:0] note_code;
   logic [DUR_W-1:0]  beat_cnt;
   logic              note_strobe;
   logic              note_on;
   logic              done;

   logic [DUR_W-1:0]  fetch_dur;
   logic [NOTE_W-1:0] fetch_note;
   logic              at_marker;
   logic              loop_back;

   logic              timer_en;
   logic              timer_clr;
   logic              tick_wrap;
   logic [TICK_W-1:0] tick_cnt;
   logic              note_end;
   logic              gap_clear;

   logic              load_note;
   logic              addr_zero;
   logic              addr_inc;
   logic              clear_note;
   logic              pulse_done;
   logic              beat_dec;
   logic              note_on_nxt;

   assign fetch_dur  = entry_dur(bus.rom_data);
   assign fetch_note = entry_note(bus.rom_data);
   assign at_marker  = (fetch_dur == END_DUR);
   assign loop_back  = (LOOP != 0) && (rom_addr != '0);

   // The timer only runs in an undisturbed HOLD; any other state clears it
   // so the next note starts its first beat from zero.
   assign timer_en  = (state == HOLD) && !bus.stop && !bus.start && !bus.pause;
   assign timer_clr = (state != HOLD) || bus.stop || bus.start;

   beat_timer #(
      .TICK_DIV (TICK_DIV),
      .TICK_W   (TICK_W)
   ) u_beat_timer (
      .clk      (sys_clk),
      .rst_n    (rst_n),
      .en       (timer_en),
      .clr      (timer_clr),
      .wrap     (tick_wrap),
      .tick_cnt (tick_cnt)
   );

   // Last cycle of the last beat of the current note
   assign note_end = tick_wrap && (beat_cnt == DUR_W'(1));

   // More than GAP_CYC cycles remain in the note. Because GAP_CYC < TICK_DIV
   // the gap always falls inside the final beat, so no multiply is needed.
   assign gap_clear = (beat_cnt > DUR_W'(1)) || (32'(tick_cnt) < SOUND_LIMIT);

   // State register
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: stop beats start, start beats everything else, and a
   // paused HOLD simply never reaches note_end
   always_comb begin
      state_nxt = state;
      if (bus.stop) begin
         state_nxt = IDLE;
      end else if (bus.start) begin
         state_nxt = FETCH;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = IDLE;
            end
            FETCH: begin
               if (!at_marker) begin
                  state_nxt = HOLD;
               end else if (loop_back) begin
                  state_nxt = FETCH;
               end else begin
                  state_nxt = IDLE;
               end
            end
            HOLD: begin
               if (note_end) begin
                  state_nxt = FETCH;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // Output/control decode for the datapath registers. Address 0 holding a
   // marker means an empty score, which ends with done even when looping.
   always_comb begin
      load_note   = 1'b0;
      addr_zero   = 1'b0;
      addr_inc    = 1'b0;
      clear_note  = 1'b0;
      pulse_done  = 1'b0;
      beat_dec    = 1'b0;
      note_on_nxt = 1'b0;
      if (bus.stop) begin
         clear_note = 1'b1;
      end else if (bus.start) begin
         addr_zero = 1'b1;
      end else begin
         case (state)
            FETCH: begin
               if (!at_marker) begin
                  load_note = 1'b1;
               end else if (loop_back) begin
                  addr_zero = 1'b1;
               end else begin
                  pulse_done = 1'b1;
                  clear_note = 1'b1;
               end
            end
            HOLD: begin
               beat_dec    = tick_wrap;
               addr_inc    = note_end;
               note_on_nxt = !bus.pause && (note_code != REST_NOTE) && gap_clear;
            end
            default: begin
            end
         endcase
      end
   end

   // Datapath registers. The address simply wraps past the top of the ROM.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr    <= '0;
         note_code   <= REST_NOTE;
         beat_cnt    <= '0;
         note_strobe <= 1'b0;
         note_on     <= 1'b0;
         done        <= 1'b0;
      end else begin
         note_strobe <= load_note;
         note_on     <= note_on_nxt;
         done        <= pulse_done;

         if (addr_zero) begin
            rom_addr <= '0;
         end else if (addr_inc) begin
            rom_addr <= rom_addr + ADDR_W'(1);
         end

         if (clear_note) begin
            note_code <= REST_NOTE;
         end else if (load_note) begin
            note_code <= fetch_note;
         end

         if (load_note) begin
            beat_cnt <= fetch_dur;
         end else if (beat_dec) begin
            beat_cnt <= beat_cnt - DUR_W'(1);
         end
      end
   end

   assign bus.rom_addr    = rom_addr;
   assign bus.note_code   = note_code;
   assign bus.note_on     = note_on;
   assign bus.note_strobe = note_strobe;
   assign bus.done        = done;
   assign bus.playing     = (state != IDLE);

endmodule

// File: tb/tb_score_sequencer.sv
// ---------------------------------------------------------------------------
// tb_score_sequencer
//
// Bench for score_sequencer with TICK_DIV=4, GAP_CYC=1, ADDR_W=4. One DUT
// runs with LOOP=0, a second with LOOP=1; both read the same score ROM.
// Cycle c of a sequence means: inputs driven 1 ns after posedge c, outputs
// sampled 4 ns after that posedge.
// ---------------------------------------------------------------------------
module tb_score_sequencer;

   localparam int ADDR_W   = 4;
   localparam int TICK_DIV = 4;
   localparam int GAP_CYC  = 1;

   localparam int SEL_ON     = 0;
   localparam int SEL_STROBE = 1;
   localparam int SEL_DONE   = 2;
   localparam int SEL_PLAY   = 3;

   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic [15:0] rom [16];

   always #5 sys_clk = ~sys_clk;

   score_sequencer_if #(.ADDR_W(ADDR_W)) seq_if ();
   score_sequencer_if #(.ADDR_W(ADDR_W)) loop_if ();

   assign seq_if.rom_data  = rom[seq_if.rom_addr];
   assign loop_if.rom_data = rom[loop_if.rom_addr];

   score_sequencer #(
      .ADDR_W   (ADDR_W),
      .TICK_DIV (TICK_DIV),
      .GAP_CYC  (GAP_CYC),
      .LOOP     (0)
   ) dut (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .bus     (seq_if)
   );

   score_sequencer #(
      .ADDR_W   (ADDR_W),
      .TICK_DIV (TICK_DIV),
      .GAP_CYC  (GAP_CYC),
      .LOOP     (1)
   ) dut_loop (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .bus     (loop_if)
   );

   typedef struct {
      logic        start;
      logic        exp_strobe;
      logic [11:0] exp_code;
      logic        exp_on;
      logic        exp_play;
      logic        exp_done;
   } vec_t;

   vec_t        vecs [18];

   int          checks = 0;
   int          passes = 0;

   logic        on_hist     [64];
   logic        strobe_hist [64];
   logic        done_hist   [64];
   logic        play_hist   [64];
   logic [11:0] code_hist   [64];

   int          strobe_cyc  [3];
   logic [11:0] strobe_code [3];
   int          strobe_num;
   logic        loop_done_seen;
   logic        loop_play_c16;

   function automatic vec_t mkVec(input logic s, input logic sb, input logic [11:0] code,
                                  input logic on, input logic pl, input logic dn);
      vec_t v;
      v.start      = s;
      v.exp_strobe = sb;
      v.exp_code   = code;
      v.exp_on     = on;
      v.exp_play   = pl;
      v.exp_done   = dn;
      return v;
   endfunction

   function automatic int countHigh(input int sel, input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++) begin
         case (sel)
            SEL_ON:     n += (on_hist[c] === 1'b1) ? 1 : 0;
            SEL_STROBE: n += (strobe_hist[c] === 1'b1) ? 1 : 0;
            SEL_DONE:   n += (done_hist[c] === 1'b1) ? 1 : 0;
            default:    n += (play_hist[c] === 1'b1) ? 1 : 0;
         endcase
      end
      return n;
   endfunction

   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic p, input logic ps);
      @(posedge sys_clk);
      #1;
      seq_if.start = s;
      seq_if.stop  = p;
      seq_if.pause = ps;
      #3;
   endtask

   task automatic loadRom(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
      for (int i = 0; i < 16; i++) begin
         rom[i] = 16'h0000;
      end
      rom[0] = w0;
      rom[1] = w1;
      rom[2] = w2;
   endtask

   // Start on cycle 0, optional pause window, optional stop+start on abort_at
   task automatic runTrace(input int n, input int pause_lo, input int pause_hi, input int abort_at);
      for (int c = 0; c < n; c++) begin
         applyStimulus((c == 0) || (c == abort_at), (c == abort_at),
                       (c >= pause_lo) && (c <= pause_hi));
         on_hist[c]     = seq_if.note_on;
         strobe_hist[c] = seq_if.note_strobe;
         done_hist[c]   = seq_if.done;
         play_hist[c]   = seq_if.playing;
         code_hist[c]   = seq_if.note_code;
      end
   endtask

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n         = 1'b0;
      seq_if.start  = 1'b0;
      seq_if.stop   = 1'b0;
      seq_if.pause  = 1'b0;
      loop_if.start = 1'b0;
      loop_if.stop  = 1'b0;
      loop_if.pause = 1'b0;
      loadRom(16'h1123, 16'h2456, 16'h0000);

      // Score {0x1_123, 0x2_456, end}, LOOP=0, hand-traced cycle by cycle
      vecs[0]  = mkVec(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
      vecs[1]  = mkVec(1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
      vecs[2]  = mkVec(1'b0, 1'b1, 12'h123, 1'b0, 1'b1, 1'b0);
      vecs[3]  = mkVec(1'b0, 1'b0, 12'h123, 1'b1, 1'b1, 1'b0);
      vecs[4]  = mkVec(1'b0, 1'b0, 12'h123, 1'b1, 1'b1, 1'b0);
      vecs[5]  = mkVec(1'b0, 1'b0, 12'h123, 1'b1, 1'b1, 1'b0);
      vecs[6]  = mkVec(1'b0, 1'b0, 12'h123, 1'b0, 1'b1, 1'b0);
      vecs[7]  = mkVec(1'b0, 1'b1, 12'h456, 1'b0, 1'b1, 1'b0);
      vecs[8]  = mkVec(1'b0, 1'b0, 12'h456, 1'b1, 1'b1, 1'b0);
      vecs[9]  = mkVec(1'b0, 1'b0, 12'h456, 1'b1, 1'b1, 1'b0);
      vecs[10] = mkVec(1'b0, 1'b0, 12'h456, 1'b1, 1'b1, 1'b0);
      vecs[11] = mkVec(1'b0, 1'b0, 12'h456, 1'b1, 1'b1, 1'b0);
      vecs[12] = mkVec(1'b0, 1'b0, 12'h456, 1'b1, 1'b1, 1'b0);
      vecs[13] = mkVec(1'b0, 1'b0, 12'h456, 1'b1, 1'b1, 1'b0);
      vecs[14] = mkVec(1'b0, 1'b0, 12'h456, 1'b1, 1'b1, 1'b0);
      vecs[15] = mkVec(1'b0, 1'b0, 12'h456, 1'b0, 1'b1, 1'b0);
      vecs[16] = mkVec(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
      vecs[17] = mkVec(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);

      // Reset state
      repeat (3) @(posedge sys_clk);
      #4;
      checkOutput("reset_rom_addr",    0, 32'(seq_if.rom_addr),    32'h0);
      checkOutput("reset_note_code",   0, 32'(seq_if.note_code),   32'h0);
      checkOutput("reset_note_on",     0, 32'(seq_if.note_on),     32'h0);
      checkOutput("reset_note_strobe", 0, 32'(seq_if.note_strobe), 32'h0);
      checkOutput("reset_playing",     0, 32'(seq_if.playing),     32'h0);
      checkOutput("reset_done",        0, 32'(seq_if.done),        32'h0);
      @(posedge sys_clk);
      #2;
      rst_n = 1'b1;

      // Table-driven main score
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].start, 1'b0, 1'b0);
         checkOutput("tbl_strobe", i, 32'(seq_if.note_strobe), 32'(vecs[i].exp_strobe));
         checkOutput("tbl_code",   i, 32'(seq_if.note_code),   32'(vecs[i].exp_code));
         checkOutput("tbl_on",     i, 32'(seq_if.note_on),     32'(vecs[i].exp_on));
         checkOutput("tbl_play",   i, 32'(seq_if.playing),     32'(vecs[i].exp_play));
         checkOutput("tbl_done",   i, 32'(seq_if.done),        32'(vecs[i].exp_done));
      end

      // LOOP=1: strobes at 2 (0x123), 7 (0x456), extra FETCH at 16, 17 (0x123)
      strobe_num     = 0;
      loop_done_seen = 1'b0;
      loop_play_c16  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         strobe_cyc[i]  = -1;
         strobe_code[i] = 12'hfff;
      end
      for (int c = 0; c < 19; c++) begin
         @(posedge sys_clk);
         #1;
         loop_if.start = (c == 0);
         #3;
         if (loop_if.note_strobe === 1'b1) begin
            if (strobe_num < 3) begin
               strobe_cyc[strobe_num]  = c;
               strobe_code[strobe_num] = loop_if.note_code;
            end
            strobe_num++;
         end
         if (loop_if.done !== 1'b0) loop_done_seen = 1'b1;
         if (c == 16) loop_play_c16 = loop_if.playing;
      end
      checkOutput("loop_strobe_count", 0, 32'(strobe_num),     32'd3);
      checkOutput("loop_strobe_cycle", 0, 32'(strobe_cyc[0]),  32'd2);
      checkOutput("loop_strobe_code",  0, 32'(strobe_code[0]), 32'h123);
      checkOutput("loop_strobe_cycle", 1, 32'(strobe_cyc[1]),  32'd7);
      checkOutput("loop_strobe_code",  1, 32'(strobe_code[1]), 32'h456);
      checkOutput("loop_strobe_cycle", 2, 32'(strobe_cyc[2]),  32'd17);
      checkOutput("loop_strobe_code",  2, 32'(strobe_code[2]), 32'h123);
      checkOutput("loop_done_seen",    0, 32'(loop_done_seen), 32'h0);
      checkOutput("loop_play_refetch", 0, 32'(loop_play_c16),  32'h1);
      @(posedge sys_clk);
      #1;
      loop_if.stop = 1'b1;
      @(posedge sys_clk);
      #1;
      loop_if.stop = 1'b0;
      #3;
      checkOutput("loop_stop_play", 0, 32'(loop_if.playing),   32'h0);
      checkOutput("loop_stop_code", 0, 32'(loop_if.note_code), 32'h0);
      checkOutput("loop_stop_done", 0, 32'(loop_if.done),      32'h0);

      // Rest 0x3_000: 12 silent HOLD cycles, then 1 FETCH, next strobe at 15
      loadRom(16'h3000, 16'h1123, 16'h0000);
      runTrace(22, -1, -1, -1);
      checkOutput("rest_strobe",       2,  32'(strobe_hist[2]),                32'h1);
      checkOutput("rest_code",         2,  32'(code_hist[2]),                  32'h000);
      checkOutput("rest_on_count",     0,  32'(countHigh(SEL_ON, 0, 15)),      32'd0);
      checkOutput("rest_early_strobe", 0,  32'(countHigh(SEL_STROBE, 3, 14)),  32'd0);
      checkOutput("rest_next_strobe",  15, 32'(strobe_hist[15]),               32'h1);
      checkOutput("rest_next_code",    15, 32'(code_hist[15]),                 32'h123);
      checkOutput("rest_next_on",      16, 32'(on_hist[16]),                   32'h1);
      checkOutput("rest_done",         20, 32'(done_hist[20]),                 32'h1);

      // Pause cycles 5..14 in a 2-beat note: note end moves from 11 to 21
      loadRom(16'h2456, 16'h1123, 16'h0000);
      runTrace(28, 5, 14, -1);
      checkOutput("pause_strobe",      2,  32'(strobe_hist[2]),                32'h1);
      checkOutput("pause_code",        2,  32'(code_hist[2]),                  32'h456);
      checkOutput("pause_on_before",   4,  32'(on_hist[4]),                    32'h1);
      checkOutput("pause_on_count",    0,  32'(countHigh(SEL_ON, 6, 15)),      32'd0);
      checkOutput("pause_playing",     10, 32'(play_hist[10]),                 32'h1);
      checkOutput("pause_on_resume",   16, 32'(on_hist[16]),                   32'h1);
      checkOutput("pause_no_strobe",   0,  32'(countHigh(SEL_STROBE, 3, 20)),  32'd0);
      checkOutput("pause_next_strobe", 21, 32'(strobe_hist[21]),               32'h1);
      checkOutput("pause_next_code",   21, 32'(code_hist[21]),                 32'h123);
      checkOutput("pause_done",        26, 32'(done_hist[26]),                 32'h1);

      // Empty score: done at cycle 2, never sounds
      loadRom(16'h0000, 16'h1123, 16'h0000);
      runTrace(6, -1, -1, -1);
      checkOutput("empty_done",        2, 32'(done_hist[2]),                   32'h1);
      checkOutput("empty_done_count",  0, 32'(countHigh(SEL_DONE, 0, 5)),      32'd1);
      checkOutput("empty_on_count",    0, 32'(countHigh(SEL_ON, 0, 5)),        32'd0);
      checkOutput("empty_strobe",      0, 32'(countHigh(SEL_STROBE, 0, 5)),    32'd0);
      checkOutput("empty_play",        1, 32'(play_hist[1]),                   32'h1);
      checkOutput("empty_play",        2, 32'(play_hist[2]),                   32'h0);

      // stop and start together on cycle 4: stop wins, no done
      loadRom(16'h2456, 16'h1123, 16'h0000);
      runTrace(8, -1, -1, 4);
      checkOutput("abort_on_before",   4, 32'(on_hist[4]),                     32'h1);
      checkOutput("abort_play",        5, 32'(play_hist[5]),                   32'h0);
      checkOutput("abort_on",          5, 32'(on_hist[5]),                     32'h0);
      checkOutput("abort_code",        5, 32'(code_hist[5]),                   32'h000);
      checkOutput("abort_done_count",  0, 32'(countHigh(SEL_DONE, 0, 7)),      32'd0);
      checkOutput("abort_play_count",  0, 32'(countHigh(SEL_PLAY, 5, 7)),      32'd0);

      // Asynchronous reset in the middle of the second note (rom_addr = 1)
      loadRom(16'h1123, 16'h2456, 16'h0000);
      runTrace(10, -1, -1, -1);
      checkOutput("arst_on_before",    9, 32'(on_hist[9]),                     32'h1);
      checkOutput("arst_addr_before",  9, 32'(seq_if.rom_addr),                32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_rom_addr",     0, 32'(seq_if.rom_addr),                32'h0);
      checkOutput("arst_note_code",    0, 32'(seq_if.note_code),               32'h0);
      checkOutput("arst_note_on",      0, 32'(seq_if.note_on),                 32'h0);
      checkOutput("arst_note_strobe",  0, 32'(seq_if.note_strobe),             32'h0);
      checkOutput("arst_playing",      0, 32'(seq_if.playing),                 32'h0);
      checkOutput("arst_done",         0, 32'(seq_if.done),                    32'h0);
      @(posedge sys_clk);
      #2;
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("arst_idle_play",    0, 32'(seq_if.playing),                 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
